handshake_credit_tx: RTL and testbench
======================================

# handshake_credit_tx

Transmit-side endpoint of a credit-based link: converts an upstream valid/ready stream into a registered, ready-less downstream beat stream. Sending is gated by a local credit counter that starts at the receiver's buffer depth, is consumed by each sent beat and is replenished by single-cycle credit-return pulses. It pairs with the receive-side token storage on the far end of the link, and adds an enable/drain state machine so the link can be quiesced safely.

## Interface
- Credits, default 4: receiver buffer depth and initial credit count; must be ≥ 1.
- DataWidth, default 8: beat payload width.

- clk_i  input  1  clock; all logic on the rising edge.
- arst_ni  input  1  reset: asynchronous, active-low.
- enable_i  input  1  level; link enable request.
- in_data_i  input  DataWidth  upstream payload.
- in_valid_i  input  1  upstream valid.
- in_ready_o  output  1  upstream ready (combinational from registered state).
- out_data_o  output  DataWidth  registered downstream payload.
- out_valid_o  output  1  registered downstream beat strobe; no ready exists.
- credit_i  input  1  one credit returned per asserted cycle.
- credit_cnt_o  output  $clog2(Credits+1)  current credits held.
- idle_o  output  1  high in IDLE (all credits home, link disabled).
- err_overflow_o  output  1  sticky credit-overflow error.

## Operation
- States: IDLE, ACTIVE, DRAIN.
  - IDLE -> ACTIVE when enable_i = 1.
  - ACTIVE -> DRAIN when enable_i = 0.
  - DRAIN -> IDLE when credit_cnt_o == Credits, evaluated on registered count.
  - DRAIN ignores enable_i. Re-enable takes effect only after IDLE is reached.
- in_ready_o = (state == ACTIVE) && (credit_cnt_o != 0).
- send = in_valid_i && in_ready_o.
- Credit update:
  - Normal: cnt_next = cnt − send + credit_i.
  - Arithmetic is in width $clog2(Credits+1) and never wraps.
  - If credit_i = 1 while cnt == Credits, the credit is discarded and err_overflow_o sets.
  - In that case cnt_next = cnt − send, and the error stays set until reset.
- Credit returns are counted in every state, including IDLE. A credit in IDLE with cnt == Credits is an overflow.
- Send and credit in the same cycle: the net count is unchanged, unless the overflow rule applies.
- When credit_cnt_o == 0, a credit arriving that cycle does not enable a send that same cycle. Ready rises the next cycle.
- Output register:
  - On send: out_valid_o = 1 and out_data_o = in_data_i on the next cycle.
  - Otherwise out_valid_o = 0 and out_data_o holds its last value.

## Timing
- Reset values: state IDLE, credit_cnt_o = Credits, out_valid_o = 0, out_data_o = 0, err_overflow_o = 0, idle_o = 1, in_ready_o = 0.
- Reset mid-operation: in-flight beats are dropped and the count returns to Credits immediately (asynchronous). The far end must be reset together with this block.
- Latency:
  - Upstream handshake to downstream beat: 1 cycle.
  - credit_i to credit_cnt_o: 1 cycle.
  - enable_i rise in IDLE to in_ready_o: 1 cycle (state register).
- Throughput is 1 beat/cycle while credits remain. Sustained rate is Credits / round-trip when the credit loop is longer than Credits cycles.
- in_valid_i may drop without a handshake. Beats are never generated without send.
- idle_o falls the cycle after the IDLE -> ACTIVE transition and rises the cycle after the DRAIN -> IDLE condition is met.

## Test plan
- **Reset:** hold arst_ni low, then release. Expect credit_cnt_o = 4, idle_o = 1, in_ready_o = 0, out_valid_o = 0, err_overflow_o = 0.
- **Credit exhaustion:** Credits = 4, enable_i = 1, in_valid_i = 1 continuously, credit_i = 0, data 0xA0..0xA5.
  - Expect four out_valid_o pulses with 0xA0..0xA3, each one cycle after its handshake.
  - Expect credit_cnt_o 4 -> 0 and in_ready_o low from then on.
  - Beat 0xA4 is not accepted.
- **Recovery from zero:** at cnt 0, pulse credit_i once. Expect in_ready_o high the next cycle, 0xA4 accepted, cnt 0 -> 1 -> 0.
- **Simultaneous send and credit:** at cnt = 2, send and credit_i in the same cycle. Expect cnt stays 2 and the beat appears on out_valid_o next cycle.
- **Drain:** with 3 credits outstanding, drop enable_i.
  - Expect in_ready_o = 0 next cycle and the state held in DRAIN.
  - After 3 credit_i pulses: cnt = 4, idle_o = 1.
  - Asserting enable_i mid-drain must not restore ready.
- **Overflow:** at cnt = 4, pulse credit_i. Expect cnt stays 4 and err_overflow_o = 1 and stays 1 through subsequent traffic until arst_ni.

Source files
------------

// File: rtl/handshake_credit_tx.sv
// Transmit endpoint of a credit-based link.
// Upstream valid/ready beats become registered, ready-less downstream beats.
// A beat is sent only while the local credit count is nonzero. Each sent beat
// consumes one credit, and each credit_i pulse returns one credit.
// An enable/drain state machine quiesces the link: after enable_i drops,
// sending stops, and the block goes idle once every credit has come home.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | link disabled, all credits home; waits for enable_i
// ACTIVE | link enabled; beats are sent while credits remain
// DRAIN  | link disabled, beats still in flight; waits for all credits

module handshake_credit_tx #(
   parameter int unsigned Credits   = 4,
   parameter int unsigned DataWidth = 8,
   localparam int unsigned CntW     = $clog2(Credits + 1)
) (
   input  logic                 clk_i,
   input  logic                 arst_ni,
   input  logic                 enable_i,
   input  logic [DataWidth-1:0] in_data_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   output logic [DataWidth-1:0] out_data_o,
   output logic                 out_valid_o,
   input  logic                 credit_i,
   output logic [CntW-1:0]      credit_cnt_o,
   output logic                 idle_o,
   output logic                 err_overflow_o
);

   localparam logic [CntW-1:0] CntMax = CntW'(Credits);
   localparam logic [CntW-1:0] CntOne = CntW'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DRAIN  = 2'd2
   } state_e;

   state_e                 state_q;
   logic [CntW-1:0]        cnt_q;
   logic [CntW-1:0]        cnt_next;
   logic [DataWidth-1:0]   data_q;
   logic                   valid_q;
   logic                   idle_q;
   logic                   err_q;

   logic                   send;
   logic                   cnt_full;
   logic                   credit_ok;
   logic                   overflow;

   // Ready is derived only from registered state, so a credit arriving while
   // the count is zero cannot enable a send in that same cycle.
   assign in_ready_o = (state_q == ACTIVE) && (cnt_q != '0);
   assign send       = in_valid_i && in_ready_o;

   // Credit bookkeeping. A return while the count is already full is dropped
   // and flagged. The count cannot wrap: send needs cnt != 0, and an accepted
   // credit needs cnt != Credits.
   always_comb begin
      cnt_full  = (cnt_q == CntMax);
      credit_ok = credit_i && !cnt_full;
      overflow  = credit_i && cnt_full;
      cnt_next  = cnt_q;
      unique case ({send, credit_ok})
         2'b10:   cnt_next = cnt_q - CntOne;
         2'b01:   cnt_next = cnt_q + CntOne;
         default: cnt_next = cnt_q;
      endcase
   end

   // State machine, credit counter, output beat register and sticky error.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state_q <= IDLE;
         idle_q  <= 1'b1;
         cnt_q   <= CntMax;
         valid_q <= 1'b0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_next;
         valid_q <= send;
         if (send) begin
            data_q <= in_data_i;
         end
         if (overflow) begin
            err_q <= 1'b1;
         end

         unique case (state_q)
            IDLE: begin
               if (enable_i) begin
                  state_q <= ACTIVE;
                  idle_q  <= 1'b0;
               end
            end
            ACTIVE: begin
               if (!enable_i) begin
                  state_q <= DRAIN;
               end
            end
            DRAIN: begin
               // The decision uses the registered count. enable_i is ignored
               // here, so a re-enable waits until every credit is home.
               if (cnt_full) begin
                  state_q <= IDLE;
                  idle_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               idle_q  <= 1'b1;
            end
         endcase
      end
   end

   assign out_data_o     = data_q;
   assign out_valid_o    = valid_q;
   assign credit_cnt_o   = cnt_q;
   assign idle_o         = idle_q;
   assign err_overflow_o = err_q;

endmodule

// File: tb/tb_handshake_credit_tx.sv
// Bench for handshake_credit_tx. A behavioural model of the link endpoint
// predicts every output. A compare process checks the outputs each cycle, and
// directed literal checks pin the model at the key points of the scenario.

module tb_handshake_credit_tx;

   localparam int CREDITS = 4;
   localparam int DW      = 8;
   localparam int CW      = $clog2(CREDITS + 1);

   logic          clk_i = 1'b0;
   logic          arst_ni;
   logic          enable_i;
   logic [DW-1:0] in_data_i;
   logic          in_valid_i;
   logic          in_ready_o;
   logic [DW-1:0] out_data_o;
   logic          out_valid_o;
   logic          credit_i;
   logic [CW-1:0] credit_cnt_o;
   logic          idle_o;
   logic          err_overflow_o;

   int n_total = 0;
   int n_pass  = 0;

   handshake_credit_tx #(.Credits(CREDITS), .DataWidth(DW)) dut (
      .clk_i          (clk_i),
      .arst_ni        (arst_ni),
      .enable_i       (enable_i),
      .in_data_i      (in_data_i),
      .in_valid_i     (in_valid_i),
      .in_ready_o     (in_ready_o),
      .out_data_o     (out_data_o),
      .out_valid_o    (out_valid_o),
      .credit_i       (credit_i),
      .credit_cnt_o   (credit_cnt_o),
      .idle_o         (idle_o),
      .err_overflow_o (err_overflow_o)
   );

   always #5 clk_i = ~clk_i;

   // Model state. Link mode is kept as 0 = off, 1 = running, 2 = draining.
   int      m_credits;
   int      m_mode;
   bit      m_out_valid;
   int      m_out_data;
   bit      m_err;
   bit      m_idle;
   bit      m_ready;
   bit      m_send;
   bit      m_ovf;

   always_comb begin
      m_ready = (m_mode == 1) && (m_credits > 0);
      m_send  = in_valid_i && m_ready;
      m_ovf   = credit_i && (m_credits == CREDITS);
   end

   always @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         m_credits   <= CREDITS;
         m_mode      <= 0;
         m_out_valid <= 1'b0;
         m_out_data  <= 0;
         m_err       <= 1'b0;
         m_idle      <= 1'b1;
      end else begin
         m_credits   <= m_credits - int'(m_send) + int'(credit_i && !m_ovf);
         m_out_valid <= m_send;
         if (m_send) m_out_data <= int'(in_data_i);
         if (m_ovf) m_err <= 1'b1;
         if (m_mode == 0 && enable_i) begin
            m_mode <= 1;
            m_idle <= 1'b0;
         end else if (m_mode == 1 && !enable_i) begin
            m_mode <= 2;
         end else if (m_mode == 2 && m_credits == CREDITS) begin
            m_mode <= 0;
            m_idle <= 1'b1;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                    name, act, act, exp, exp, $time);
   endtask

   // Every-cycle comparison against the model, sampled on the falling edge.
   always @(negedge clk_i) begin
      if (arst_ni) begin
         chk("cnt",       int'(credit_cnt_o),   m_credits);
         chk("ready",     int'(in_ready_o),     int'(m_ready));
         chk("out_valid", int'(out_valid_o),    int'(m_out_valid));
         chk("out_data",  int'(out_data_o),     m_out_data);
         chk("idle",      int'(idle_o),         int'(m_idle));
         chk("err",       int'(err_overflow_o), int'(m_err));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   initial begin
      arst_ni    = 1'b0;
      enable_i   = 1'b0;
      in_valid_i = 1'b0;
      in_data_i  = '0;
      credit_i   = 1'b0;
      cyc(3);
      arst_ni = 1'b1;
      #1;
      chk("rst_cnt",   int'(credit_cnt_o),   4);
      chk("rst_idle",  int'(idle_o),         1);
      chk("rst_ready", int'(in_ready_o),     0);
      chk("rst_valid", int'(out_valid_o),    0);
      chk("rst_err",   int'(err_overflow_o), 0);

      // Credit exhaustion: A0..A3 go out, A4 is held off.
      cyc(1);
      enable_i   = 1'b1;
      in_valid_i = 1'b1;
      in_data_i  = 8'hA0;
      repeat (10) begin
         cyc(1);
         if (m_out_valid) in_data_i = in_data_i + 8'd1;
      end
      chk("exh_cnt",   int'(credit_cnt_o), 0);
      chk("exh_ready", int'(in_ready_o),   0);
      chk("exh_valid", int'(out_valid_o),  0);
      chk("exh_data",  int'(out_data_o),   8'hA3);
      chk("exh_next",  int'(in_data_i),    8'hA4);

      // Recovery from zero credits.
      credit_i = 1'b1;
      cyc(1);
      credit_i = 1'b0;
      chk("rec_ready", int'(in_ready_o),   1);
      chk("rec_cnt1",  int'(credit_cnt_o), 1);
      cyc(1);
      in_valid_i = 1'b0;
      chk("rec_valid", int'(out_valid_o),  1);
      chk("rec_data",  int'(out_data_o),   8'hA4);
      chk("rec_cnt0",  int'(credit_cnt_o), 0);

      // Send and credit in the same cycle at cnt = 2.
      credit_i = 1'b1;
      cyc(2);
      credit_i = 1'b0;
      chk("sim_pre", int'(credit_cnt_o), 2);
      in_valid_i = 1'b1;
      in_data_i  = 8'hA5;
      credit_i   = 1'b1;
      cyc(1);
      in_valid_i = 1'b0;
      credit_i   = 1'b0;
      chk("sim_cnt",   int'(credit_cnt_o), 2);
      chk("sim_valid", int'(out_valid_o),  1);
      chk("sim_data",  int'(out_data_o),   8'hA5);

      // Three credits outstanding, then drain.
      in_valid_i = 1'b1;
      in_data_i  = 8'hA6;
      cyc(1);
      in_valid_i = 1'b0;
      chk("drn_pre", int'(credit_cnt_o), 1);
      enable_i = 1'b0;
      cyc(1);
      chk("drn_ready", int'(in_ready_o), 0);
      chk("drn_idle",  int'(idle_o),     0);
      enable_i = 1'b1;
      credit_i = 1'b1;
      cyc(1);
      credit_i = 1'b0;
      cyc(1);
      chk("drn_reen_ready", int'(in_ready_o),   0);
      chk("drn_cnt2",       int'(credit_cnt_o), 2);
      credit_i = 1'b1;
      cyc(1);
      credit_i = 1'b0;
      chk("drn_reen_ready2", int'(in_ready_o), 0);
      enable_i = 1'b0;
      credit_i = 1'b1;
      cyc(1);
      credit_i = 1'b0;
      chk("drn_cnt4",  int'(credit_cnt_o), 4);
      chk("drn_still", int'(idle_o),       0);
      cyc(1);
      chk("drn_idle1", int'(idle_o), 1);

      // Overflow in IDLE, then sticky through mixed traffic.
      credit_i = 1'b1;
      cyc(1);
      credit_i = 1'b0;
      chk("ovf_cnt", int'(credit_cnt_o),   4);
      chk("ovf_err", int'(err_overflow_o), 1);
      enable_i   = 1'b1;
      in_valid_i = 1'b1;
      in_data_i  = 8'hB0;
      for (int i = 0; i < 12; i++) begin
         credit_i = (i % 3 == 2) ? 1'b1 : 1'b0;
         cyc(1);
         if (m_out_valid) in_data_i = in_data_i + 8'd1;
      end
      in_valid_i = 1'b0;
      credit_i   = 1'b0;
      cyc(2);
      chk("ovf_sticky", int'(err_overflow_o), 1);

      // Reset mid-operation restores everything asynchronously.
      in_valid_i = 1'b1;
      credit_i   = 1'b1;
      cyc(1);
      arst_ni = 1'b0;
      #1;
      chk("arst_cnt",   int'(credit_cnt_o),   4);
      chk("arst_valid", int'(out_valid_o),    0);
      chk("arst_idle",  int'(idle_o),         1);
      chk("arst_err",   int'(err_overflow_o), 0);
      chk("arst_ready", int'(in_ready_o),     0);
      chk("arst_data",  int'(out_data_o),     0);
      in_valid_i = 1'b0;
      credit_i   = 1'b0;
      enable_i   = 1'b0;
      cyc(2);
      arst_ni = 1'b1;
      cyc(3);
      chk("end_cnt", int'(credit_cnt_o), 4);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
